// File: rtl/mem_responder.sv
// Word-addressed SRAM responder for a DM/IOM-style initiator port, with programmable wait states.
// Latency: accept edge, then LATENCY wait cycles, then one completion cycle with ready high.
// Backpressure: ready stays low from the request cycle until the completion cycle; the initiator holds enable meanwhile.
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        error
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_data;

    logic [31:0] mem [DEPTH];

    logic                 cur_write;
    logic [31:0]          cur_address;
    logic [31:0]          cur_data;
    logic                 cur_legal;
    logic [ADDR_BITS-1:0] cur_index;
    logic                 finish;

    // The access being worked on: live inputs while idle (needed when LATENCY=0
    // accepts and completes on the same edge), the latched copy afterwards.
    always_comb begin
        cur_write   = req_write;
        cur_address = req_address;
        cur_data    = req_data;
        if (state == IDLE) begin
            cur_write   = write && !read;
            cur_address = address;
            cur_data    = data_in;
        end
        cur_legal = (cur_address[31:ADDR_BITS+2] == '0) && (cur_address[1:0] == 2'b00);
        cur_index = cur_address[ADDR_BITS+1:2];
        finish    = ((state == IDLE) && enable && ZERO_LAT) ||
                    ((state == BUSY) && (count == 4'd0));
    end

    // Fresh requests must never see a stale ready, hence the enable gating in IDLE.
    assign ready = ((state == IDLE) && !enable) || (state == DONE);

    // Legal writes commit on the edge entering DONE; reset discards an uncommitted write.
    always_ff @(posedge clock) begin
        if (!reset && finish && cur_write && cur_legal) begin
            mem[cur_index] <= cur_data;
        end
    end

    // Handshake FSM with registered read data and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 4'd0;
            data_out    <= 32'd0;
            error       <= 1'b0;
            req_write   <= 1'b0;
            req_address <= 32'd0;
            req_data    <= 32'd0;
        end else begin
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        req_write   <= write && !read;
                        req_address <= address;
                        req_data    <= data_in;
                        count       <= CNT_INIT;
                        state       <= ZERO_LAT ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (finish) begin
                error <= !cur_legal;
                if (!cur_write) begin
                    data_out <= cur_legal ? mem[cur_index] : 32'd0;
                end
            end
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder for the CPU's DM/IOM-style port: it samples enable/read/write/address/data from the initiator, inserts a programmable number of wait states, and returns read data with a ready handshake. It is the slave end of the interface the CPU and its data cache drive. It sits between the cache/IO memory-controller outputs and on-chip SRAM, and doubles as the bench memory model.

## Interface
- ADDR_BITS, 10, word-index width; depth = 2^ADDR_BITS 32-bit words
- LATENCY, 2, wait cycles per access, legal 0..15

- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- enable  input  1  request strobe, held by initiator until ready completes it
- read  input  1  read request qualifier
- write  input  1  write request qualifier
- address  input  32  byte address; word index = address[ADDR_BITS+1:2]
- data_in  input  32  write data
- data_out  output  32  read data, registered
- ready  output  1  high = idle with no request, or access completing this cycle
- error  output  1  high in the completing cycle of an out-of-range or misaligned access

## Operation
- Access type: write when write=1 and read=0; every other enabled combination is a read.
- States:
  - IDLE: no access in progress.
  - BUSY: wait states; a 4-bit counter loaded with LATENCY-1 decrements each cycle.
  - DONE: completion cycle, lasts exactly one cycle.
- Transitions:
  - IDLE with enable=1: request accepted at the edge. Latch type, address and data_in. Go to BUSY if LATENCY>0, else DONE.
  - BUSY: go to DONE on the edge where the counter equals 0.
  - DONE always returns to IDLE. The held request is not re-accepted.
- ready = (IDLE && !enable) || DONE. The combinational gating on enable stops a fresh request from seeing a stale ready.
- Range/alignment: illegal when address[31:ADDR_BITS+2] != 0 or address[1:0] != 0.
  - Illegal reads load data_out with 0.
  - Illegal writes are dropped.
  - error is asserted in DONE for either case.
- Legal read: data_out ← mem[index] on the edge entering DONE.
- Legal write: mem[index] ← latched data; committed on the edge entering DONE. data_out is unchanged.
- Inputs other than enable are ignored outside IDLE; latched values are used.
- Memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, data_out 0, error 0. ready follows !enable.
- Accept edge = cycle 0. ready is low in cycles 0..LATENCY and high in cycle LATENCY+1 (DONE).
  - With LATENCY=0: accept in cycle 0, DONE in cycle 1, so ready is low for exactly one cycle.
  - Total request-to-completion = LATENCY+2 cycles counting the request cycle.
- Back-to-back: a new request may be presented in the cycle after DONE. It is accepted that edge, giving a minimum issue interval of LATENCY+2 cycles.
- data_out is valid in DONE and holds until the next completing read or reset.
- Write-then-read to the same word returns the new data. The write commits before the read is accepted.
- Reset mid-access (BUSY or DONE): return to IDLE next cycle. An uncommitted write is discarded, data_out is cleared, and no error pulse occurs.
- enable dropped while BUSY: the access still completes. The initiator protocol forbids this, and the bench flags it as a warning only.

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> ready low for 3 cycles on each access, then high for 1 cycle; read data_out = 0xDEADBEEF, error = 0.
- LATENCY=0: read from an unwritten-after-preload address 0x4 preloaded with 0x1234_5678 -> ready low 1 cycle; data_out = 0x12345678 in cycle 1.
- Out of range, ADDR_BITS=10: write 0x5555 to 0x0000_1000, then read 0x0000_1000 -> error=1 in each DONE; read data_out = 0; word 0 unchanged.
- Misaligned read at 0x0000_0013 -> data_out = 0, error = 1 in DONE only.
- Reset asserted in cycle 1 of a LATENCY=3 write of 0xA5A5A5A5 to 0x20 -> ready=1 (enable low) after reset; later read of 0x20 returns the prior value, not 0xA5A5A5A5.
- Back-to-back alternating writes/reads over 256 random legal addresses vs. a scoreboard -> all reads match, every request sees exactly LATENCY+1 ready-low cycles, no error pulses.
